// File: rtl/vec1024_word_reader_if.sv
// Handshake bundle for the vector word reader: a wide load channel in, a
// word-at-a-time output channel out, plus the busy status flag.
interface vec1024_word_reader_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 32
);
  localparam int IDX_W = $clog2(NUM_WORDS);

  logic                        load_valid;
  logic                        load_ready;
  logic [WORD_W*NUM_WORDS-1:0] load_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W-1:0]           out_data;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        busy;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/vec1024_word_reader.sv
// Captures one wide vector and streams it out as NUM_WORDS words, lowest
// word first, with a valid/ready handshake and fully registered outputs.
module vec1024_word_reader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  vec1024_word_reader_if.slave    bus
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state;
  logic [NUM_WORDS-1:0][WORD_W-1:0] buffer;
  logic [IDX_W-1:0]                 index;
  logic [IDX_W-1:0]                 next_index;
  logic [WORD_W-1:0]                data_q;
  logic                             last_q;
  logic                             valid_q;
  logic                             ready_q;
  logic                             busy_q;

  assign next_index = index + IDX_W'(1);

  // The next word is preselected from the held buffer so the output word
  // register updates on the same edge that retires the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      buffer  <= '0;
      index   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            buffer  <= bus.load_data;
            index   <= '0;
            data_q  <= bus.load_data[WORD_W-1:0];
            last_q  <= (LAST_IDX == '0);
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (index == LAST_IDX) begin
              index   <= '0;
              data_q  <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              index  <= next_index;
              data_q <= buffer[next_index];
              last_q <= (next_index == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_index  = index;
  assign bus.out_last   = last_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/vec1024_word_reader.md
VEC1024_WORD_READER -- requirements
Module: vec1024_word_reader

Interface
REQ-001 The block SHALL define parameter WORD_W, default 32, meaning the output word width in bits.
REQ-002 The block SHALL define parameter NUM_WORDS, default 32, meaning the number of words per vector; vector width = WORD_W*NUM_WORDS = 1024.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 load_valid  input  1  a vector is offered on load_data.
REQ-006 load_ready  output  1  the block can accept a vector.
REQ-007 load_data  input  1024  vector to read out, e.g. a 1024-bit bitwise result.
REQ-008 out_valid  output  1  out_data/out_index/out_last hold a valid word.
REQ-009 out_ready  input  1  the consumer accepts the current word.
REQ-010 out_data  output  32  current word.
REQ-011 out_index  output  5  index k (0..31) of the current word.
REQ-012 out_last  output  1  current word is word 31.
REQ-013 busy  output  1  a vector is captured and not fully read out.

Function
REQ-014 The block SHALL implement two states, IDLE and SEND.
REQ-015 In IDLE: load_ready=1, out_valid=0, busy=0.
REQ-016 Load handshake: load_valid=1 and load_ready=1 at a rising edge SHALL capture load_data into an internal 1024-bit buffer, set index to 0, and enter SEND.
REQ-017 In SEND: load_ready=0, out_valid=1, busy=1; load_valid SHALL be ignored and the buffer SHALL NOT change.
REQ-018 Word mapping: out_data SHALL equal buffer[32k+31:32k] for k = out_index, so word 0 is bits 31:0 and word 31 is bits 1023:992.
REQ-019 out_last SHALL equal 1 exactly when out_valid=1 and out_index=31.
REQ-020 Word handshake: out_valid=1 and out_ready=1 at a rising edge SHALL retire the current word. If index<31, index SHALL increment by 1 and the state SHALL remain SEND. If index=31, the state SHALL return to IDLE.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable with no change on any cycle.
REQ-022 Latency: word 0 SHALL be valid in the first cycle after the load handshake.
REQ-023 Throughput: with out_ready held at 1, the block SHALL retire one word per cycle, delivering 32 words in 32 consecutive cycles.
REQ-024 load_ready SHALL reassert in the cycle after word 31 retires, giving a minimum of 33 cycles per vector; load and readout SHALL NOT overlap.
REQ-025 Index SHALL NOT wrap past 31. Reaching index 31 SHALL always end readout through IDLE.
REQ-026 out_ready asserted in IDLE SHALL have no effect.
REQ-027 out_data, out_index and out_last SHALL be driven directly from registers, with no combinational path from any input to them.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force IDLE with index=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, load_ready=1 and buffer=0.
REQ-029 Reset during SEND SHALL discard the captured vector; no further words of it SHALL be emitted after reset deasserts.
REQ-030 After rst deasserts, the first load handshake SHALL be accepted on the first rising edge at which load_valid=1.

Verification
REQ-031 Basic stream: load_data with word k = 32'h0000_0100+k, out_ready=1 constantly -> 32 words 0x100..0x11F on consecutive cycles, out_index 0..31, out_last=1 only on 0x11F, load_ready=1 on the following cycle.
REQ-032 Backpressure: toggle out_ready 1,0,0,1,... during readout -> no word skipped or duplicated, out_data stable while stalled, sequence identical to REQ-031.
REQ-033 Ignored load: during SEND, assert load_valid with load_data = all-ones -> remaining words still come from the first vector; load_ready stays 0 until word 31 retires.
REQ-034 Async reset mid-stream: assert rst between clock edges after word 10 retires -> outputs go to 0 and load_ready to 1 before the next edge; a new vector of all 32'hA5A5_A5A5 words then streams from index 0.
REQ-035 Back-to-back: load_valid held at 1 with two different vectors -> second vector accepted exactly one cycle after the first vector's word 31 retires; total 66 cycles for both with out_ready=1.
REQ-036 Boundary data: load_data = 1024'h1 followed by a vector with only bit 1023 set -> word 0 = 0x00000001 on the first vector and word 31 = 0x80000000 on the second; all other words = 0.
